// File: rtl/bsearch_ctrl.sv
// bsearch_ctrl: successive-approximation controller for a magnitude comparator.
// Drives the comparator x operand and binary-searches [0, 2^width-1] using the
// xgy/xsy/xey flags until the guess equals the comparator's y target.
// Build option: define BSEARCH_REG_CMP_EN to insert a WAIT cycle before each
// flag sample, so the block can drive a comparator with registered flags.
module bsearch_ctrl #(
    parameter int width = 3,
    parameter int cnt_w = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [width-1:0] x,
    input  logic             xgy,
    input  logic             xsy,
    input  logic             xey,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [width-1:0] result,
    output logic [cnt_w-1:0] steps
);

`ifdef BSEARCH_REG_CMP_EN
    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_cmp  = 2'd1,
        st_done = 2'd2,
        st_wait = 2'd3
    } state_t;
    // every new guess gets one settling cycle before its flags are sampled
    localparam state_t probe_state_c = st_wait;
`else
    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_cmp  = 2'd1,
        st_done = 2'd2
    } state_t;
    localparam state_t probe_state_c = st_cmp;
`endif

    localparam logic [width-1:0] max_c  = {width{1'b1}};
    localparam logic [width-1:0] zero_c = {width{1'b0}};
    localparam logic [width-1:0] mid_c  = max_c >> 1'b1;
    localparam logic [cnt_w-1:0] one_c  = {{(cnt_w-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [width-1:0]   x_r, x_s;
    logic [width-1:0]   lo_r, lo_s;
    logic [width-1:0]   hi_r, hi_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic [width-1:0]   result_r, result_s;
    logic [cnt_w-1:0]   steps_r, steps_s;

    // width+1 bit helpers so neither x+1 nor the midpoint sums can overflow
    logic [width:0]     xp1_s;
    logic [width:0]     xm1_s;
    logic [width:0]     sum_up_s;
    logic [width:0]     sum_dn_s;
    logic [2:0]         flags_s;

    // next-state and next-value logic for every register in the block
    always_comb begin
        state_s  = state_r;
        x_s      = x_r;
        lo_s     = lo_r;
        hi_s     = hi_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        err_s    = err_r;
        result_s = result_r;
        steps_s  = steps_r;

        xp1_s    = {1'b0, x_r} + {{width{1'b0}}, 1'b1};
        xm1_s    = {1'b0, x_r} - {{width{1'b0}}, 1'b1};
        sum_up_s = xp1_s + {1'b0, hi_r};
        sum_dn_s = {1'b0, lo_r} + xm1_s;
        flags_s  = {xgy, xsy, xey};

        case (state_r)
            st_idle: begin
                if (start) begin
                    lo_s     = zero_c;
                    hi_s     = max_c;
                    x_s      = mid_c;
                    steps_s  = {cnt_w{1'b0}};
                    err_s    = 1'b0;
                    result_s = zero_c;
                    busy_s   = 1'b1;
                    state_s  = probe_state_c;
                end else begin
                    state_s = st_idle;
                end
            end
            st_cmp: begin
                steps_s = steps_r + one_c;
                case (flags_s)
                    3'b001: begin
                        result_s = x_r;
                        done_s   = 1'b1;
                        state_s  = st_done;
                    end
                    3'b010: begin
                        // guess too small: move lo above it, unless nothing is left
                        if ((x_r == max_c) || (xp1_s > {1'b0, hi_r})) begin
                            err_s   = 1'b1;
                            done_s  = 1'b1;
                            state_s = st_done;
                        end else begin
                            lo_s    = width'(xp1_s);
                            x_s     = width'(sum_up_s >> 1'b1);
                            state_s = probe_state_c;
                        end
                    end
                    3'b100: begin
                        // guess too large: move hi below it, unless nothing is left
                        if ((x_r == zero_c) || (xm1_s < {1'b0, lo_r})) begin
                            err_s   = 1'b1;
                            done_s  = 1'b1;
                            state_s = st_done;
                        end else begin
                            hi_s    = width'(xm1_s);
                            x_s     = width'(sum_dn_s >> 1'b1);
                            state_s = probe_state_c;
                        end
                    end
                    default: begin
                        // no flag or contradictory flags: comparator is not trustworthy
                        err_s   = 1'b1;
                        done_s  = 1'b1;
                        state_s = st_done;
                    end
                endcase
            end
            st_done: begin
                busy_s  = 1'b0;
                state_s = st_idle;
            end
`ifdef BSEARCH_REG_CMP_EN
            st_wait: begin
                state_s = st_cmp;
            end
`endif
            default: begin
                busy_s  = 1'b0;
                state_s = st_idle;
            end
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= st_idle;
            x_r      <= zero_c;
            lo_r     <= zero_c;
            hi_r     <= max_c;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= zero_c;
            steps_r  <= {cnt_w{1'b0}};
        end else begin
            state_r  <= state_s;
            x_r      <= x_s;
            lo_r     <= lo_s;
            hi_r     <= hi_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
            result_r <= result_s;
            steps_r  <= steps_s;
        end
    end

    assign x      = x_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign result = result_r;
    assign steps  = steps_r;

endmodule

// File: tb/tb_bsearch_ctrl.sv
// tb_bsearch_ctrl: directed, table-driven bench for bsearch_ctrl with a
// behavioural comparator whose flags can be forced to faulty patterns.
module tb_bsearch_ctrl;

    localparam int W  = 3;
    localparam int CW = 4;
`ifdef BSEARCH_REG_CMP_EN
    localparam int PPC = 2;
`else
    localparam int PPC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  x;
    logic          xgy, xsy, xey;
    logic          busy, done, err;
    logic [W-1:0]  result;
    logic [CW-1:0] steps;

    int tgt;
    int mode;  // 0 normal, 1 no flags, 2 xgy+xey, 3 xsy stuck, 4 xgy stuck
    int checks = 0;
    int errors = 0;

    typedef struct {
        int tgt;
        int mode;
        int n_x;
        int seq[4];
        int res;
        int stp;
        int er;
    } vec_t;

    vec_t vecs[$];

    bsearch_ctrl #(.width(W), .cnt_w(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .xgy(xgy), .xsy(xsy), .xey(xey),
        .busy(busy), .done(done), .err(err),
        .result(result), .steps(steps)
    );

    always #5 clk = ~clk;

    // comparator model with fault injection
    always_comb begin
        xgy = 1'b0;
        xsy = 1'b0;
        xey = 1'b0;
        case (mode)
            0: begin
                xgy = int'(x) > tgt;
                xsy = int'(x) < tgt;
                xey = int'(x) == tgt;
            end
            2: begin
                xgy = 1'b1;
                xey = 1'b1;
            end
            3: xsy = 1'b1;
            4: xgy = 1'b1;
            default: ;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int t, input int m, input int n,
                       input int s0, input int s1, input int s2, input int s3,
                       input int res, input int stp, input int er);
        vec_t v;
        v.tgt = t; v.mode = m; v.n_x = n;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3;
        v.res = res; v.stp = stp; v.er = er;
        vecs.push_back(v);
    endtask

    // poke: 0 none, 1 start pulse mid-search, 2 start held in the done cycle
    task automatic run(input vec_t v, input int poke);
        int cyc;
        int n;
        int last;
        int got;
        int seq[4];
        tgt  = v.tgt;
        mode = v.mode;
        for (int i = 0; i < 4; i++) seq[i] = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 1;
        n    = 0;
        last = -1;
        got  = 0;
        while (cyc <= 40) begin
            if (done) begin
                got = 1;
                break;
            end
            if (cyc == 1) chk("busy_during", int'(busy), 1);
            if (int'(x) != last) begin
                if (n < 4) seq[n] = int'(x);
                n++;
                last = int'(x);
            end
            start = (poke == 1 && cyc == 2);
            @(negedge clk);
            cyc++;
        end
        start = (poke == 2);
        if (got == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within %0d cycles for target %0d", cyc, v.tgt);
        end else begin
            chk("latency", cyc, PPC * v.stp + 1);
            chk("result", int'(result), v.res);
            chk("steps", int'(steps), v.stp);
            chk("err", int'(err), v.er);
            chk("x_count", n, v.n_x);
            for (int i = 0; i < 4; i++)
                if (i < v.n_x) chk("x_seq", seq[i], v.seq[i]);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_once", int'(done), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tgt   = 0;

        // tgt, mode, n_x, seq0..3, result, steps, err
        add(3, 0, 1, 3, 0, 0, 0, 3, 1, 0);
        add(7, 0, 4, 3, 5, 6, 7, 7, 4, 0);
        add(0, 0, 3, 3, 1, 0, 0, 0, 3, 0);
        add(5, 0, 2, 3, 5, 0, 0, 5, 2, 0);
        add(1, 0, 2, 3, 1, 0, 0, 1, 2, 0);
        add(2, 0, 3, 3, 1, 2, 0, 2, 3, 0);
        add(4, 0, 3, 3, 5, 4, 0, 4, 3, 0);
        add(6, 0, 3, 3, 5, 6, 0, 6, 3, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0, 1, 1);
        add(6, 0, 3, 3, 5, 6, 0, 6, 3, 0);
        add(0, 2, 1, 3, 0, 0, 0, 0, 1, 1);
        add(0, 3, 4, 3, 5, 6, 7, 0, 4, 1);
        add(0, 4, 3, 3, 1, 0, 0, 0, 3, 1);
        add(5, 0, 2, 3, 5, 0, 0, 5, 2, 0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_x", int'(x), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_steps", int'(steps), 0);

        foreach (vecs[i]) run(vecs[i], 0);

        // start pulses while busy / in the done cycle must be ignored
        run(vecs[1], 1);
        run(vecs[3], 2);
        @(negedge clk);
        chk("idle_after_done_start", int'(busy), 0);

        // reset during the second probe of the target-7 search
        tgt  = 7;
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (PPC) @(negedge clk);
        chk("second_probe_x", int'(x), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_x", int'(x), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_steps", int'(steps), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_err", int'(err), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);

        // reset and start together: reset wins
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        @(negedge clk);
        chk("rst_start_still_idle", int'(busy), 0);
        chk("rst_start_x", int'(x), 0);

        run(vecs[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsearch_ctrl.md
Name: bsearch_ctrl

Overview:
- Sequential successive-approximation controller that drives the x operand of the magnitude comparator and consumes its xgy/xsy/xey flags.
- The comparator's y input is tied to an unknown target value. Using the flags, the block binary-searches the full unsigned range [0, 2^width-1] until it finds the target.
- It reports the found value, the probe count, and an error status.
- It sits directly upstream of the comparator (driving x) and directly downstream of it (consuming its flags).

Parameters:
- width, 3, operand width in bits; must match the comparator's width.
- cnt_w, 4, width of the probe counter; must satisfy 2^cnt_w > width+1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a search; accepted only in IDLE.
- x  output  width  current guess, registered; wired to comparator x.
- xgy  input  1  comparator flag: guess > target.
- xsy  input  1  comparator flag: guess < target.
- xey  input  1  comparator flag: guess == target.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse at search completion.
- err  output  1  search failed; held until the next accepted start.
- result  output  width  found target value; held until the next accepted start.
- steps  output  cnt_w  number of comparisons performed; held until the next accepted start.

Behaviour:
- Single clock domain. Reset is synchronous, active-high: one clock, clk; reset rst.
- Reset values: state=IDLE; x=0; busy=0; done=0; err=0; result=0; steps=0; internal lo=0; hi=2^width-1.
- States: IDLE, CMP, DONE.
- IDLE, start=1:
  - lo<=0; hi<=2^width-1; x<=(2^width-1)>>1; steps<=0; err<=0; result<=0.
  - Next state CMP; busy<=1.
- IDLE, start=0: hold all outputs.
- CMP: each cycle is one probe. Flags are sampled at the clock edge ending the cycle in which x is stable. steps<=steps+1 on every CMP cycle.
  - xey only: result<=x; go to DONE.
  - xsy only:
    - If x==2^width-1 or x+1>hi: err<=1; go to DONE.
    - Else lo<=x+1; x<=(x+1+hi)>>1; stay in CMP.
  - xgy only:
    - If x==0 or x-1<lo: err<=1; go to DONE.
    - Else hi<=x-1; x<=(lo+x-1)>>1; stay in CMP.
  - Zero flags set, or more than one flag set: err<=1; go to DONE.
- Midpoint arithmetic:
  - lo+hi is computed in width+1 bits, then shifted right by 1 (floor). No overflow.
  - Unsigned compares only.
- DONE: done=1 for exactly this cycle; busy<=0; next state IDLE.
  - result, steps and err hold until the next accepted start.
  - x holds its last value.
- Latency: start sampled at edge k; the first probe is evaluated at edge k+1.
  - A search with N probes raises done in the cycle after edge k+N, i.e. N+1 cycles after start is sampled.
  - Maximum N = width+1.
- start while busy or in DONE: ignored, with no side effects.
- rst asserted mid-search: returns to IDLE with reset values at the next edge. The aborted search produces no done pulse.
- rst and start high together: rst wins.

Optional Feature:
- Macro: BSEARCH_REG_CMP_EN.
- Defined:
  - Adds a WAIT state between each x update and its CMP sample, for use with a registered comparator.
  - Flags are sampled 2 cycles after x changes, so each probe takes 2 cycles. IDLE on start goes to WAIT.
  - N-probe latency becomes 2N+1 cycles.
  - steps still counts probes, not cycles.
- Undefined: 1 cycle per probe as above. The WAIT state does not exist.

Test Plan:
- width=3, target y=3, start pulse at cycle 0 -> x=3 at cycle 1; done at cycle 2; result=3; steps=1; err=0.
- target 7 -> x sequence 3,5,6,7; done 5 cycles after start; result=7; steps=4; err=0.
- target 0 -> x sequence 3,1,0; result=0; steps=3; err=0. Then start again with target 5 -> sequence 3,5; steps=2; err cleared.
- Flags forced to all-zero, then separately to xgy=xey=1 -> err=1 after first probe; steps=1; result=0; done pulses once.
- Flag xsy stuck at 1 -> x sequence 3,5,6,7; err=1 at guess 7; steps=4.
- rst pulsed during the second probe of the target-7 search -> next cycle: IDLE, x=0, busy=0, steps=0, no done pulse. Start pulsed while busy -> sequence unchanged.
- With BSEARCH_REG_CMP_EN: target 7 -> done 9 cycles after start; steps=4.
